// File: rtl/ahb_pkg.sv
// AHB-Lite bus encodings and controller state type shared by the BRAM
// controller and its lane decoder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

endpackage

// File: rtl/ahb_lane_dec.sv
// Maps transfer size and low address bits to a BRAM byte-lane mask and
// flags sizes/alignments this slave cannot serve.
module ahb_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] haddr_lo_i,
  output logic [3:0] mask_o,
  output logic       illegal_o
);

  always_comb begin
    mask_o    = 4'b0000;
    illegal_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: mask_o = 4'b0001 << haddr_lo_i;
      HSIZE_HALF: begin
        mask_o    = haddr_lo_i[1] ? 4'b1100 : 4'b0011;
        illegal_o = haddr_lo_i[0];
      end
      HSIZE_WORD: begin
        mask_o    = 4'b1111;
        illegal_o = |haddr_lo_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait-state AHB-Lite slave in front of a dual-port BRAM, with a
// read-after-write forwarding buffer and a two-cycle ERROR response.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_WADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_RADDR,
  input  logic [31:0]           BRAM_RDATA
);

  state_e                  state_q, state_d;
  logic                    wr_pend_q, wr_pend_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [3:0]              wr_mask_q, wr_mask_d;
  logic                    fwd_valid_q, fwd_valid_d;
  logic [3:0]              fwd_mask_q, fwd_mask_d;
  logic [31:0]             fwd_data_q, fwd_data_d;

  logic                    accept;
  logic                    legal_acc;
  logic [3:0]              lane_mask;
  logic                    lane_illegal;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    unused_bits;

  // High address bits alias; HTRANS[0] only distinguishes NONSEQ from SEQ.
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign word_addr = HADDR[ADDR_WIDTH+1:2];
  assign accept    = HSEL & HTRANS[1] & HREADY & (state_q != ST_ERR1);
  assign legal_acc = accept & ~lane_illegal;

  ahb_lane_dec u_lane_dec (
    .hsize_i    (HSIZE),
    .haddr_lo_i (HADDR[1:0]),
    .mask_o     (lane_mask),
    .illegal_o  (lane_illegal)
  );

  always_comb begin
    state_d     = state_q;
    wr_pend_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_mask_d   = wr_mask_q;
    fwd_valid_d = 1'b0;
    fwd_mask_d  = fwd_mask_q;
    fwd_data_d  = fwd_data_q;

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) state_d = lane_illegal ? ST_ERR1 : ST_DATA;
        else        state_d = ST_IDLE;
      end
    endcase

    if (legal_acc && HWRITE) begin
      wr_pend_d = 1'b1;
      wr_addr_d = word_addr;
      wr_mask_d = lane_mask;
    end

    // The BRAM returns the pre-write word here, so capture the bytes in flight.
    if (legal_acc && !HWRITE && wr_pend_q && (word_addr == wr_addr_q)) begin
      fwd_valid_d = 1'b1;
      fwd_mask_d  = wr_mask_q;
      fwd_data_d  = HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_mask_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_mask_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_mask_q   <= wr_mask_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_mask_q  <= fwd_mask_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign HREADYOUT  = (state_q != ST_ERR1);
  assign HRESP      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  assign BRAM_WE    = wr_pend_q ? wr_mask_q : 4'b0000;
  assign BRAM_WADDR = wr_addr_q;
  assign BRAM_WDATA = HWDATA;
  assign BRAM_RADDR = word_addr;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign HRDATA[8*gi +: 8] = (fwd_valid_q && fwd_mask_q[gi]) ? fwd_data_q[8*gi +: 8]
                                                               : BRAM_RDATA[8*gi +: 8];
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboard bench for ahb_bram_ctrl: the driver queues expected data-phase
// responses, a monitor pops and compares them against the live bus.
module tb_ahb_bram_ctrl;

  localparam int AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] BRAM_WADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WE;
  logic [AW-1:0] BRAM_RADDR;
  logic [31:0]   BRAM_RDATA;

  always #5 HCLK = ~HCLK;

  // Single-slave interconnect: bus ready follows this slave.
  assign HREADY = HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .BRAM_WADDR (BRAM_WADDR),
    .BRAM_WDATA (BRAM_WDATA),
    .BRAM_WE    (BRAM_WE),
    .BRAM_RADDR (BRAM_RADDR),
    .BRAM_RDATA (BRAM_RDATA)
  );

  // Read-first BRAM with one-cycle registered read.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge HCLK) begin
    BRAM_RDATA <= mem[BRAM_RADDR];
    for (int b = 0; b < 4; b++)
      if (BRAM_WE[b]) mem[BRAM_WADDR][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
  end

  typedef struct {
    string       name;
    bit          is_wr;
    logic [3:0]  we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    bit          is_rd;
    logic [31:0] rdata;
    bit          rdy;
    bit          resp;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic dp_active = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    else pass_cnt++;
  endtask

  task automatic push_wr(input string nm, input logic [3:0] we, input logic [11:0] wa,
                         input logic [31:0] wd);
    exp_t e;
    e.name = nm; e.is_wr = 1; e.we = we; e.waddr = wa; e.wdata = wd;
    e.is_rd = 0; e.rdata = '0; e.rdy = 1; e.resp = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input string nm, input logic [31:0] rd);
    exp_t e;
    e.name = nm; e.is_wr = 0; e.we = '0; e.waddr = '0; e.wdata = '0;
    e.is_rd = 1; e.rdata = rd; e.rdy = 1; e.resp = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input string nm);
    exp_t e;
    e.name = {nm, "_c1"}; e.is_wr = 0; e.we = '0; e.waddr = '0; e.wdata = '0;
    e.is_rd = 0; e.rdata = '0; e.rdy = 0; e.resp = 1;
    exp_q.push_back(e);
    e.name = {nm, "_c2"}; e.rdy = 1;
    exp_q.push_back(e);
  endtask

  // Data phase starts after an accepted address phase and stretches while HREADYOUT=0.
  always @(posedge HCLK)
    dp_active <= HRESETn && ((HSEL && HTRANS[1] && HREADY) || (dp_active && !HREADYOUT));

  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      chk("reset_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("reset_hresp",     32'(HRESP),     32'd0);
      chk("reset_we",        32'(BRAM_WE),   32'd0);
    end else if (dp_active) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL dphase_without_expectation: got data phase, required none queued");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_hreadyout"}, 32'(HREADYOUT), 32'(e.rdy));
        chk({e.name, "_hresp"},     32'(HRESP),     32'(e.resp));
        if (e.is_wr) begin
          chk({e.name, "_we"},    32'(BRAM_WE),    32'(e.we));
          chk({e.name, "_waddr"}, 32'(BRAM_WADDR), 32'(e.waddr));
          chk({e.name, "_wdata"}, BRAM_WDATA,      e.wdata);
        end else begin
          chk({e.name, "_we"}, 32'(BRAM_WE), 32'd0);
        end
        if (e.is_rd) chk({e.name, "_hrdata"}, HRDATA, e.rdata);
        $display("txn %s: hreadyout=%0b hresp=%0b we=%b waddr=0x%03h wdata=0x%08h hrdata=0x%08h",
                 e.name, HREADYOUT, HRESP, BRAM_WE, BRAM_WADDR, BRAM_WDATA, HRDATA);
      end
    end else begin
      chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("idle_hresp",     32'(HRESP),     32'd0);
      chk("idle_we",        32'(BRAM_WE),   32'd0);
    end
  end

  task automatic bus_cyc(input logic sel, input logic [1:0] trans, input logic [31:0] a,
                         input logic [2:0] sz, input logic wr, input logic [31:0] wd);
    HSEL = sel; HTRANS = trans; HADDR = a; HSIZE = sz; HWRITE = wr; HWDATA = wd;
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                         input logic [31:0] wd);
    bus_cyc(1'b1, 2'b10, a, sz, wr, wd);
  endtask

  task automatic idle_ph(input logic [31:0] wd);
    bus_cyc(1'b0, 2'b00, 32'h0, 3'd0, 1'b0, wd);
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL = 0; HADDR = '0; HTRANS = 2'b00; HSIZE = '0; HWRITE = 0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle_ph(0);

    // Word write, then read back after an idle cycle.
    push_wr("w_deadbeef", 4'b1111, 12'h004, 32'hDEADBEEF);
    addr_ph(32'h10, 3'd2, 1, 0);
    idle_ph(32'hDEADBEEF);
    idle_ph(0);
    push_rd("r_deadbeef", 32'hDEADBEEF);
    addr_ph(32'h10, 3'd2, 0, 0);
    idle_ph(0);

    // Byte write lane 3 over a preset word (back-to-back writes).
    push_wr("w_preset10", 4'b1111, 12'h004, 32'h11223344);
    addr_ph(32'h10, 3'd2, 1, 0);
    push_wr("w_byte13", 4'b1000, 12'h004, 32'hAA000000);
    addr_ph(32'h13, 3'd0, 1, 32'h11223344);
    idle_ph(32'hAA000000);
    push_rd("r_byte13", 32'hAA223344);
    addr_ph(32'h10, 3'd2, 0, 0);
    idle_ph(0);

    // Half write immediately followed by a read of the same word: forwarded.
    push_wr("w_preset20", 4'b1111, 12'h008, 32'h12345678);
    addr_ph(32'h20, 3'd2, 1, 0);
    idle_ph(32'h12345678);
    push_wr("w_half20", 4'b0011, 12'h008, 32'h0000BEEF);
    addr_ph(32'h20, 3'd1, 1, 0);
    push_rd("r_fwd20", 32'h1234BEEF);
    addr_ph(32'h20, 3'd2, 0, 32'h0000BEEF);
    idle_ph(0);

    // Write to neighbouring word must not forward into a read of 0x20.
    push_wr("w_byte24", 4'b0001, 12'h009, 32'h000000C3);
    addr_ph(32'h24, 3'd0, 1, 0);
    push_rd("r_nofwd20", 32'h1234BEEF);
    addr_ph(32'h20, 3'd2, 0, 32'h000000C3);
    idle_ph(0);

    // Address bits above the BRAM range alias.
    push_rd("r_alias4020", 32'h1234BEEF);
    addr_ph(32'h4020, 3'd2, 0, 0);
    idle_ph(0);

    // Misaligned word read and misaligned half write.
    push_err("e_misalign22");
    addr_ph(32'h22, 3'd2, 0, 0);
    idle_ph(0);
    idle_ph(0);
    push_err("e_half21");
    addr_ph(32'h21, 3'd1, 1, 0);
    idle_ph(0);
    idle_ph(0);

    // Oversize write errors, legal read in ERR2, target word unchanged.
    push_wr("w_preset30", 4'b1111, 12'h00C, 32'h55555555);
    addr_ph(32'h30, 3'd2, 1, 0);
    idle_ph(32'h55555555);
    push_err("e_size3");
    addr_ph(32'h30, 3'd3, 1, 0);
    idle_ph(32'hFFFFFFFF);
    push_rd("r_in_err2", 32'hAA223344);
    addr_ph(32'h10, 3'd2, 0, 32'hFFFFFFFF);
    idle_ph(0);
    push_rd("r_30_kept", 32'h55555555);
    addr_ph(32'h30, 3'd2, 0, 0);
    idle_ph(0);

    // Illegal transfer accepted in ERR2 restarts the error sequence.
    push_err("e_first");
    addr_ph(32'h31, 3'd1, 0, 0);
    idle_ph(0);
    push_err("e_again");
    addr_ph(32'h33, 3'd2, 0, 0);
    idle_ph(0);
    idle_ph(0);

    // BUSY and unselected transfers are not accepted.
    bus_cyc(1'b1, 2'b01, 32'h10, 3'd2, 1, 0);
    bus_cyc(1'b0, 2'b10, 32'h10, 3'd2, 1, 32'h01010101);
    idle_ph(32'h02020202);
    push_rd("r_10_untouched", 32'hAA223344);
    addr_ph(32'h10, 3'd2, 0, 0);
    idle_ph(0);

    // Reset asserted during a write data phase discards the write.
    push_wr("w_preset40", 4'b1111, 12'h010, 32'hCAFEF00D);
    addr_ph(32'h40, 3'd2, 1, 0);
    idle_ph(32'hCAFEF00D);
    addr_ph(32'h40, 3'd2, 1, 0);
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
    #1 HRESETn = 1'b0;
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle_ph(0);
    push_rd("r_40_kept", 32'hCAFEF00D);
    addr_ph(32'h40, 3'd2, 0, 0);
    idle_ph(0);

    repeat (3) idle_ph(0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
- AHB-Lite subordinate that sits between the Cortex-M0 bus matrix and the dual-port block RAM.
- Converts AHB address/data-phase transfers into BRAM write-port signals (word address, data, 4-bit byte enable) and read-port signals (word address, returned word).
- Zero-wait-state reads and writes; a forwarding buffer resolves read-after-write to the same word.
- Illegal transfers receive a two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 12, BRAM word-address width; byte-address bits used are [ADDR_WIDTH+1:0].

Ports:
- HCLK  in  1  bus clock, shared with the BRAM clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  subordinate select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  subordinate ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data (data phase)
- BRAM_WADDR  out  ADDR_WIDTH  write word address
- BRAM_WDATA  out  32  write data
- BRAM_WE  out  4  byte write enables
- BRAM_RADDR  out  ADDR_WIDTH  read word address
- BRAM_RDATA  in  32  BRAM registered read data (1-cycle latency)

Behaviour:
- Reset values (async on HRESETn low): HREADYOUT=1, HRESP=0, BRAM_WE=0, state=IDLE, all phase and forwarding registers 0.
- Accept: transfer accepted when HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers are not accepted and get OKAY with zero wait.
- Legality:
  - HSIZE > 2 is illegal.
  - Misalignment is illegal: size 1 with HADDR[0]=1, or size 2 with HADDR[1:0]!=0.
  - Address bits above ADDR_WIDTH+1 are ignored (aliasing).
- Byte lanes:
  - size 0: 1<<HADDR[1:0]
  - size 1: HADDR[1] ? 1100 : 0011
  - size 2: 1111
- Write path:
  - On accepted legal write, register word address and lane mask.
  - In the following data phase: BRAM_WE = mask, BRAM_WADDR = registered address, BRAM_WDATA = HWDATA.
  - The BRAM commits at the end of the data phase.
  - BRAM_WE is 0 in every other cycle.
- Read path:
  - BRAM_RADDR = HADDR[ADDR_WIDTH+1:2] combinationally in every cycle, so the BRAM samples it at the address-phase edge.
  - HRDATA = BRAM_RDATA in the data phase; zero wait states.
- Forwarding:
  - Hazard case: a read address phase coincides with a write data phase to the same word. The BRAM returns the old word in this case.
  - At that edge, register fwd_valid=1, fwd_mask = write mask, fwd_data = HWDATA.
  - In the read data phase, for each byte with fwd_mask=1, HRDATA takes that byte from fwd_data instead of BRAM_RDATA.
  - fwd_valid clears on any edge without a new hazard.
- State machine:
  - IDLE/DATA: normal pipelined operation, HREADYOUT=1.
  - On an accepted illegal transfer → ERR1: HREADYOUT=0, HRESP=1, no BRAM write.
  - ERR1 → ERR2: HREADYOUT=1, HRESP=1.
  - ERR2 → IDLE, or → DATA if a new legal transfer is accepted in ERR2. If that transfer is illegal → ERR1 again.
  - An address phase presented during ERR1 is not accepted (HREADY=0).
- Reset mid-transfer: a pending write is discarded (BRAM_WE forced 0), the error sequence aborts, and fwd_valid clears.
- HWDATA is sampled only in the write data phase.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
  - HSIZE codes (BYTE=0, HALF=1, WORD=2)
  - HRESP codes
  - error state encoding
- Sub-module ahb_lane_dec: combinational HSIZE + HADDR[1:0] → 4-bit lane mask plus illegal flag.
- The BRAM is instantiated outside this block by the integrator.

Test Plan:
- Word write 0xDEADBEEF @0x0000_0010, then idle, then word read @0x10 → BRAM_WE=1111 with BRAM_WADDR=4 in the write data phase; HRDATA=0xDEADBEEF, zero wait states.
- Byte write 0xAA @0x13 over a word preset to 0x11223344 → BRAM_WE=1000, BRAM_WDATA=0xAA000000 (HWDATA lane 3 = 0xAA); subsequent read returns 0xAA223344.
- Back-to-back half write 0xBEEF @0x20 (HWDATA=0x0000BEEF) then read @0x20 over preset 0x12345678 → forwarded HRDATA=0x1234BEEF in the read data phase.
- Misaligned word read @0x22 → HREADYOUT 0 then 1 with HRESP=1 for both cycles; BRAM_WE stays 0.
- HSIZE=3 write → ERROR response, no write. A legal read issued in ERR2 completes with OKAY on the next cycle.
- HRESETn asserted during a write data phase → BRAM_WE=0 immediately; HREADYOUT=1, HRESP=0; target word unchanged.
